// File: rtl/alu_add_sequencer.sv
// alu_add_sequencer: WIDTH-bit add/subtract built by sequencing one external 4-bit adder slice, LSB nibble first.
// Optional feature macro: ALU_ADD_SEQ_OVF_EN (signed overflow flag; tied to 0 when undefined).
module alu_add_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("alu_add_sequencer: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_out;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [3:0]       r_add_a;
  logic [3:0]       r_add_b;
  logic             r_carry;

  logic [WIDTH-1:0] w_b_in;
  logic             w_cin_in;
  logic             w_last;

  function automatic logic [3:0] f_nibble(input logic [WIDTH-1:0] vec, input int idx);
    return vec[idx*4 +: 4];
  endfunction

  assign w_b_in   = op_sub ? ~op_b : op_b;
  assign w_cin_in = op_sub ? 1'b1 : op_cin;
  assign w_last   = (r_cnt == LAST_SLICE);

  // The slice operands are registered one cycle ahead, so the adder sees slice k while r_cnt == k.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_add_a     <= 4'h0;
      r_add_b     <= 4'h0;
      r_carry     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= op_a;
            r_b        <= w_b_in;
            r_carry    <= w_cin_in;
            r_add_a    <= op_a[3:0];
            r_add_b    <= w_b_in[3:0];
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_RUN: begin
          r_result[int'(r_cnt)*4 +: 4] <= add_sum;
          if (w_last) begin
            r_cnt       <= '0;
            r_add_a     <= 4'h0;
            r_add_b     <= 4'h0;
            r_carry     <= 1'b0;
            r_carry_out <= add_cout;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_add_a <= f_nibble(r_a, int'(r_cnt) + 1);
            r_add_b <= f_nibble(r_b, int'(r_cnt) + 1);
            r_carry <= add_cout;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cnt       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_add_a     <= 4'h0;
          r_add_b     <= 4'h0;
          r_carry     <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_ADD_SEQ_OVF_EN
  logic r_overflow;

  // Sign of the result comes straight from the last slice sum as it is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if ((r_state == S_RUN) && w_last) begin
      r_overflow <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (add_sum[3] != r_a[WIDTH-1]);
    end else begin
      r_overflow <= r_overflow;
    end
  end

  assign overflow = r_overflow;
`else
  assign overflow = 1'b0;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign add_cin   = r_carry;

endmodule

// File: tb/tb_alu_add_sequencer.sv
// Directed self-checking bench for alu_add_sequencer at WIDTH=16 with a behavioural 4-bit adder slice.
module tb_alu_add_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_cin;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        carry_out;
  logic        overflow;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_cin;
  logic [3:0]  add_sum;
  logic        add_cout;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ALU_ADD_SEQ_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  alu_add_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry_out(carry_out), .overflow(overflow), .add_a(add_a), .add_b(add_b),
    .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op at a negedge, track it to out_valid, then complete the output handshake.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                        output logic [15:0] res, output logic co, output logic ov, output int lat,
                        output logic [3:0] cins, output logic [3:0] b0, output logic busy_ok,
                        output logic done_zero);
    cins = 4'h0; b0 = 4'h0; busy_ok = 1'b1; lat = 0;
    @(negedge clk);
    op_a = a; op_b = b; op_cin = cin; op_sub = sub; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) break;
      if (lat < 4) cins[lat] = add_cin;
      if (lat == 0) b0 = add_b;
      if (in_ready) busy_ok = 1'b0;
      lat++;
    end
    res = result; co = carry_out; ov = overflow;
    done_zero = (add_a == 4'h0) && (add_b == 4'h0) && (add_cin == 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    n_checks++; if ({result, carry_out, overflow} !== 18'h0) begin n_fail++; $display("FAIL reset outputs: got %h/%b/%b expected 0", result, carry_out, overflow); end
    n_checks++; if ({add_a, add_b, add_cin} !== 9'h0) begin n_fail++; $display("FAIL reset add_bus: got %h/%h/%b expected 0", add_a, add_b, add_cin); end
  endtask

  task automatic test_add_basic();
    logic [15:0] res; logic co, ov, bok, dz; int lat; logic [3:0] cins, b0;
    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, res, co, ov, lat, cins, b0, bok, dz);
    n_checks++; if (res !== 16'h2233) begin n_fail++; $display("FAIL add_basic result: got %h expected 2233", res); end
    n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL add_basic carry: got %b expected 0", co); end
    n_checks++; if (cins !== 4'b1110) begin n_fail++; $display("FAIL add_basic cin_seq: got %b expected 1110 (slice3..0)", cins); end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL add_basic latency: got %0d expected 4", lat); end
    n_checks++; if (bok !== 1'b1) begin n_fail++; $display("FAIL add_basic in_ready_busy: in_ready seen high during RUN"); end
    n_checks++; if (dz !== 1'b1) begin n_fail++; $display("FAIL add_basic done_add_bus: got %h/%h/%b expected 0", add_a, add_b, add_cin); end
    n_checks++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL add_basic back_to_idle: got ready/valid %b%b expected 10", in_ready, out_valid); end
  endtask

  task automatic test_add_edges();
    logic [15:0] res; logic co, ov, bok, dz; int lat; logic [3:0] cins, b0;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, res, co, ov, lat, cins, b0, bok, dz);
    n_checks++; if (res !== 16'h0000) begin n_fail++; $display("FAIL add_wrap result: got %h expected 0000", res); end
    n_checks++; if (co !== 1'b1) begin n_fail++; $display("FAIL add_wrap carry: got %b expected 1", co); end
    n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL add_wrap overflow: got %b expected 0", ov); end
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0, res, co, ov, lat, cins, b0, bok, dz);
    n_checks++; if (res !== 16'h0001) begin n_fail++; $display("FAIL add_cin result: got %h expected 0001", res); end
    n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL add_cin carry: got %b expected 0", co); end
  endtask

  task automatic test_sub();
    logic [15:0] res; logic co, ov, bok, dz; int lat; logic [3:0] cins, b0;
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, res, co, ov, lat, cins, b0, bok, dz);
    n_checks++; if (b0 !== 4'h8) begin n_fail++; $display("FAIL sub_small add_b0: got %h expected 8", b0); end
    n_checks++; if (cins !== 4'b0001) begin n_fail++; $display("FAIL sub_small cin_seq: got %b expected 0001 (slice3..0)", cins); end
    n_checks++; if (res !== 16'hFFFE) begin n_fail++; $display("FAIL sub_small result: got %h expected fffe", res); end
    n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL sub_small carry: got %b expected 0", co); end
    n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL sub_small overflow: got %b expected 0", ov); end
    // op_cin=1 must be ignored for subtract
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, res, co, ov, lat, cins, b0, bok, dz);
    n_checks++; if (res !== 16'h7FFF) begin n_fail++; $display("FAIL sub_ovf result: got %h expected 7fff", res); end
    n_checks++; if (co !== 1'b1) begin n_fail++; $display("FAIL sub_ovf carry: got %b expected 1", co); end
    n_checks++; if (ov !== OVF_ON) begin n_fail++; $display("FAIL sub_ovf overflow: got %b expected %b", ov, OVF_ON); end
  endtask

  task automatic test_backpressure();
    int waited;
    logic stable_ok, busy_ok;
    @(negedge clk);
    op_a = 16'h00FF; op_b = 16'h0001; op_cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) break;
      waited++;
    end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp done_timeout: out_valid %b after %0d cycles", out_valid, waited); end
    stable_ok = 1'b1; busy_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = ~in_valid; op_a = op_a ^ 16'hA5A5; op_b = op_b + 16'h0111; op_sub = ~op_sub;
      @(negedge clk);
      if ((result !== 16'h0100) || (carry_out !== 1'b0) || (overflow !== 1'b0) || (out_valid !== 1'b1)) stable_ok = 1'b0;
      if (in_ready !== 1'b0) busy_ok = 1'b0;
    end
    n_checks++; if (stable_ok !== 1'b1) begin n_fail++; $display("FAIL bp hold: got %h/%b/%b valid %b expected 0100/0/0 valid 1", result, carry_out, overflow, out_valid); end
    n_checks++; if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL bp in_ready: got %b expected 0 while held", in_ready); end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp release_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp release_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    n_checks++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL bp no_accept: got ready/valid %b%b expected 10", in_ready, out_valid); end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] res; logic co, ov, bok, dz; int lat; logic [3:0] cins, b0;
    @(negedge clk);
    op_a = 16'h1234; op_b = 16'h1111; op_cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL rst_mid ready_valid: got %b%b expected 10", in_ready, out_valid); end
    n_checks++; if ({add_a, add_b, add_cin} !== 9'h0) begin n_fail++; $display("FAIL rst_mid add_bus: got %h/%h/%b expected 0", add_a, add_b, add_cin); end
    n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL rst_mid result: got %h expected 0000", result); end
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, res, co, ov, lat, cins, b0, bok, dz);
    n_checks++; if (res !== 16'h8000) begin n_fail++; $display("FAIL rst_mid_follow result: got %h expected 8000", res); end
    n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL rst_mid_follow carry: got %b expected 0", co); end
    n_checks++; if (ov !== OVF_ON) begin n_fail++; $display("FAIL rst_mid_follow overflow: got %b expected %b", ov, OVF_ON); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_a = 16'h0; op_b = 16'h0; op_cin = 1'b0; op_sub = 1'b0;
    test_reset();
    test_add_basic();
    test_add_edges();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
